cbus_arbiter: RTL and testbench

- Shares the single outbound cbus port between N cbus requesters, typically the instruction-side and data-side converters.
- Sits between the IBusToCBus/DBusToCBus converters and the top-level oreq/oresp.
- Replaces the plain multiplexer.
- Grants one requester at a time and locks the grant for a whole transaction, including every burst beat, until the last-beat handshake.

---
 rtl/cbus_arbiter_if.sv | 48 ++++
 rtl/cbus_arbiter.sv | 113 +++++++++++
 tb/tb_cbus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// cbus request/response types and the arbiter's bundled port interface.
// 'slave' is the arbiter's view; 'master' is the view of the requesters and
// memory side that drive ireqs/oresp.

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  logic [3:0]  len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;
  logic       [NUM_REQ-1:0] grant;
  logic                     busy;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq,
    output grant,
    output busy
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one outbound cbus port between NUM_REQ requesters.
// A grant is locked for the whole transaction (all burst beats) and released
// on the ready&&last handshake; one IDLE arbitration cycle separates owners.
// Optional feature macro CBUS_ARB_RR_EN: round-robin priority instead of the
// default fixed lowest-index-wins priority.
//
// state | meaning
// IDLE  | no owner, outputs quiet, arbitrating among valid requests
// BUSY  | owner r_sel is steered to oreq, oresp steered back to it only

module cbus_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          resetn,
  cbus_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic             w_done;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] r_rr;

  // Winner search starting at the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.ireqs[idx].valid) begin
        w_win = IDX_W'(idx);
        w_any = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the owner when its transaction ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr <= '0;
    end else if (r_state == S_BUSY && w_done) begin
      r_rr <= (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest valid index wins (scan downward so it overwrites last).
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.ireqs[i].valid) begin
        w_win = IDX_W'(i);
        w_any = 1'b1;
      end
    end
  end
`endif

  assign w_done = bus.oresp.ready & bus.oresp.last;

  // Grant FSM: capture winner in IDLE, hold it until the last-beat handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_sel   <= w_win;
        r_state <= S_BUSY;
      end
    end else begin
      if (w_done) r_state <= S_IDLE;
    end
  end

  // Steering: pure combinational mux driven by the registered owner, so reset
  // silences oreq and iresps without waiting for a clock edge.
  always_comb begin
    bus.oreq   = '0;
    bus.iresps = '0;
    bus.grant  = '0;
    bus.busy   = 1'b0;
    if (r_state == S_BUSY) begin
      bus.oreq          = bus.ireqs[r_sel];
      bus.iresps[r_sel] = bus.oresp;
      bus.grant[r_sel]  = 1'b1;
      bus.busy          = 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(bus.grant));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!resetn)
    !(r_state == S_IDLE && bus.oreq.valid));
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_chk
    a_owner_only_ready: assert property (@(posedge clk) disable iff (!resetn)
      !(bus.iresps[j].ready && !(r_state == S_BUSY && r_sel == IDX_W'(j))));
  end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed vector table, hand-written
// reset/priority sequences and randomized traffic against an owner-tracking
// reference model.

module tb_cbus_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(N)) bus();

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus (-1 = nobody) and the next rr start.
  int m_owner = -1;
  int m_rr    = 0;

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic         lst;
    logic [N-1:0] eg;
    logic         eov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [N-1:0] v, logic rdy, logic lst,
                              logic [N-1:0] eg, logic eov);
    vec_t t;
    t.v = v; t.rdy = rdy; t.lst = lst; t.eg = eg; t.eov = eov;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic cbus_req_t rand_req(logic valid);
    cbus_req_t r;
    r.valid    = valid;
    r.is_write = 1'($urandom);
    r.size     = 3'($urandom);
    r.addr     = $urandom;
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = 4'($urandom);
    return r;
  endfunction

  function automatic int pick(logic [N-1:0] v, int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] valids();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = bus.ireqs[i].valid;
    return v;
  endfunction

  task automatic check_model(input string tag);
    cbus_req_t            e_req;
    cbus_resp_t [N-1:0]   e_resp;
    logic       [N-1:0]   e_grant;
    e_req = '0; e_resp = '0; e_grant = '0;
    if (m_owner >= 0) begin
      e_req            = bus.ireqs[m_owner];
      e_resp[m_owner]  = bus.oresp;
      e_grant[m_owner] = 1'b1;
    end
    cmp({tag, ".grant"},  128'(bus.grant),  128'(e_grant));
    cmp({tag, ".busy"},   128'(bus.busy),   128'(m_owner >= 0));
    cmp({tag, ".oreq"},   128'(bus.oreq),   128'(e_req));
    cmp({tag, ".iresps"}, 128'(bus.iresps), 128'(e_resp));
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic tick();
    int nxt_owner;
    int nxt_rr;
    nxt_owner = m_owner;
    nxt_rr    = m_rr;
    if (m_owner < 0) begin
`ifdef CBUS_ARB_RR_EN
      nxt_owner = pick(valids(), m_rr);
`else
      nxt_owner = pick(valids(), 0);
`endif
    end else if (bus.oresp.ready && bus.oresp.last) begin
      nxt_owner = -1;
      nxt_rr    = (m_owner + 1) % N;
    end
    @(posedge clk);
    m_owner = nxt_owner;
    m_rr    = nxt_rr;
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    bus.ireqs = '0;
    bus.oresp = '0;
    m_owner   = -1;
    m_rr      = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rdy, input logic lst);
    for (int i = 0; i < N; i++) bus.ireqs[i] = rand_req(v[i]);
    bus.oresp.ready = rdy;
    bus.oresp.last  = lst;
    bus.oresp.data  = $urandom;
  endtask

  initial begin
    // single requester burst
    tbl.push_back(mk(2'b10, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b10, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b10, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b10, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b10, 1, 1, 2'b10, 1));
    tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0));
    // simultaneous single-beat requests
    tbl.push_back(mk(2'b11, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b11, 1, 1, 2'b01, 1));
    tbl.push_back(mk(2'b10, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b10, 1, 1, 2'b10, 1));
    tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0));
    // locking: req0 arrives mid-burst of req1
    tbl.push_back(mk(2'b10, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b10, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b11, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b11, 1, 0, 2'b10, 1));
    tbl.push_back(mk(2'b11, 1, 1, 2'b10, 1));
    tbl.push_back(mk(2'b01, 0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b01, 1, 1, 2'b01, 1));
    tbl.push_back(mk(2'b00, 1, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 1, 1, 2'b00, 0));

    do_reset();
    cmp("reset.grant", 128'(bus.grant), 128'(0));
    cmp("reset.oreq", 128'(bus.oreq), 128'(0));
    cmp("reset.iresps", 128'(bus.iresps), 128'(0));
    cmp("reset.busy", 128'(bus.busy), 128'(0));

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].rdy, tbl[k].lst);
      #4;
      cmp($sformatf("vec%0d.grant", k), 128'(bus.grant), 128'(tbl[k].eg));
      cmp($sformatf("vec%0d.ovalid", k), 128'(bus.oreq.valid), 128'(tbl[k].eov));
      cmp($sformatf("vec%0d.busy", k), 128'(bus.busy), 128'(|tbl[k].eg));
      for (int i = 0; i < N; i++)
        cmp($sformatf("vec%0d.ready%0d", k, i), 128'(bus.iresps[i].ready),
            128'(tbl[k].eg[i] & tbl[k].rdy));
      check_model($sformatf("vec%0d", k));
      tick();
    end

    // idle with no requests
    for (int c = 0; c < 10; c++) begin
      drive(2'b00, 1'($urandom), 1'($urandom));
      #4;
      cmp("idle.ovalid", 128'(bus.oreq.valid), 128'(0));
      check_model("idle");
      tick();
    end

    // reset in the middle of a burst
    do_reset();
    drive(2'b10, 0, 0);
    #4 check_model("rst.arb");
    tick();
    drive(2'b10, 1, 0);
    #4 cmp("rst.beat1.grant", 128'(bus.grant), 128'(2'b10));
    tick();
    drive(2'b10, 1, 0);
    #2 resetn = 1'b0;
    #1;
    cmp("rst.async.ovalid", 128'(bus.oreq.valid), 128'(0));
    cmp("rst.async.grant", 128'(bus.grant), 128'(0));
    cmp("rst.async.iresps", 128'(bus.iresps), 128'(0));
    m_owner = -1;
    m_rr    = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(2'b01, 0, 0);
    #4 cmp("rst.rearb.grant", 128'(bus.grant), 128'(0));
    tick();
    #4 cmp("rst.regrant.grant", 128'(bus.grant), 128'(2'b01));
    cmp("rst.regrant.ovalid", 128'(bus.oreq.valid), 128'(1));
    check_model("rst.regrant");
    tick();

    // both requesters continuously valid, single-beat transactions
    do_reset();
    for (int t = 0; t < 12; t++) begin
      drive(2'b11, 1, 1);
      #4;
      if (t % 2 == 1) begin
`ifdef CBUS_ARB_RR_EN
        cmp($sformatf("seq%0d.grant", t / 2), 128'(bus.grant),
            128'(((t / 2) % 2 == 0) ? 2'b01 : 2'b10));
`else
        cmp($sformatf("seq%0d.grant", t / 2), 128'(bus.grant), 128'(2'b01));
`endif
      end
      check_model("seq");
      tick();
    end

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      logic rdy;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom);
      drive(v, rdy, rdy & ($urandom_range(0, 2) == 0));
      #4 check_model("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
